// File: rtl/serial_frame_pkg.sv
// ============================================================================
// Module   : serial_frame_pkg
// Purpose  : Shared state encoding, line constant and frame-length helper for
//            the serial frame transmit/receive blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

  // Clocks from accept to the return to IDLE.
  function automatic int unsigned frame_clocks(input int unsigned data_width,
                                               input int unsigned clks_per_bit,
                                               input int unsigned parity_en);
    return (2 + data_width + parity_en) * clks_per_bit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_frame_tx_bit_timer.sv
// ============================================================================
// Module   : bit_timer
// Purpose  : Counts clocks within one serial bit; bit_end marks the last one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end = en && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_frame_tx.sv
// ============================================================================
// Module   : serial_frame_tx
// Purpose  : Parallel-to-serial frame transmitter: start, LSB-first data,
//            optional parity, stop. Line idles high.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done
);

  localparam int            IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  bit_end;

  assign data_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign accept     = data_valid && data_ready;
  assign tx_out     = tx_q;
  assign done       = done_q;
  assign shreg_next = shreg_q >> 1;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (busy),
    .clr    (accept),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shreg_d = data_in;
          idx_d   = '0;
          par_d   = (^data_in) ^ ODD;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = LINE_IDLE;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_next;
            tx_d    = shreg_next[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = LINE_IDLE;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= LINE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
// ============================================================================
// Module   : tb_serial_frame_tx
// Purpose  : Self-checking bench: three transmitter configurations (even
//            parity, odd parity, no parity with one clock per bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_frame_tx;

  localparam int NDUT = 3;
  // Per-configuration settings, matching the instances below.
  localparam int CPB [NDUT] = '{4, 4, 1};
  localparam int PEN [NDUT] = '{1, 1, 0};
  localparam int POD [NDUT] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] din [NDUT];
  logic       vld [NDUT];
  logic       rdy [NDUT];
  logic       tx  [NDUT];
  logic       bsy [NDUT];
  logic       dn  [NDUT];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_even (
    .clk(clk), .reset_n(reset_n), .data_in(din[0]), .data_valid(vld[0]),
    .data_ready(rdy[0]), .tx_out(tx[0]), .busy(bsy[0]), .done(dn[0]));

  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_odd (
    .clk(clk), .reset_n(reset_n), .data_in(din[1]), .data_valid(vld[1]),
    .data_ready(rdy[1]), .tx_out(tx[1]), .busy(bsy[1]), .done(dn[1]));

  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_np (
    .clk(clk), .reset_n(reset_n), .data_in(din[2]), .data_valid(vld[2]),
    .data_ready(rdy[2]), .tx_out(tx[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference line level for serial bit number b of a frame carrying d.
  function automatic logic model_bit(input int i, input logic [7:0] d, input int b);
    int ones = 0;
    for (int k = 0; k < 8; k++) ones += d[k];
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PEN[i] != 0 && b == 9) return (POD[i] != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  function automatic int model_len(input int i);
    return (2 + 8 + PEN[i]) * CPB[i];
  endfunction

  task automatic check_idle_all(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      check_eq({tag, "_tx"},    tx[i],  1'b1);
      check_eq({tag, "_ready"}, rdy[i], 1'b1);
      check_eq({tag, "_busy"},  bsy[i], 1'b0);
      check_eq({tag, "_done"},  dn[i],  1'b0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      check_idle_all("idle");
    end
  endtask

  // Offers d at the next edge and follows the whole frame to its done cycle.
  // scramble: wiggle data_in/data_valid (including 0x11) while busy.
  // chain: present nd as valid from the last stop clock through the done cycle.
  task automatic frame(input int i, input logic [7:0] d, input bit scramble,
                       input bit chain, input logic [7:0] nd);
    int len = model_len(i);
    din[i] = d;
    vld[i] = 1'b1;
    @(posedge clk); #1;
    vld[i] = 1'b0;
    for (int k = 0; k < len; k++) begin
      check_eq("frame_tx",    tx[i],  model_bit(i, d, k / CPB[i]));
      check_eq("frame_busy",  bsy[i], 1'b1);
      check_eq("frame_ready", rdy[i], 1'b0);
      check_eq("frame_done",  dn[i],  1'b0);
      if (scramble) begin
        if (k == len / 2) begin
          din[i] = 8'h11;
          vld[i] = 1'b1;
        end else begin
          din[i] = 8'($urandom);
          vld[i] = 1'($urandom);
        end
      end
      if (k == len - 1) begin
        din[i] = nd;
        vld[i] = chain;
      end
      @(posedge clk); #1;
    end
    check_eq("done_pulse", dn[i],  1'b1);
    check_eq("done_busy",  bsy[i], 1'b0);
    check_eq("done_ready", rdy[i], 1'b1);
    check_eq("done_tx",    tx[i],  1'b1);
  endtask

  task automatic reset_mid_frame(input logic [7:0] d);
    din[0] = d;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    for (int k = 0; k < 4 * CPB[0]; k++) begin
      @(posedge clk); #1;
    end
    check_eq("pre_reset_bit3", tx[0], d[3]);
    reset_n = 1'b0;
    #1;
    check_eq("async_tx",    tx[0],  1'b1);
    check_eq("async_ready", rdy[0], 1'b1);
    check_eq("async_busy",  bsy[0], 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_idle_all("in_reset");
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i;
    int links;
    bit chain;
    logic [7:0] d, nd;
    for (int k = 0; k < NDUT; k++) begin
      din[k] = 8'h00;
      vld[k] = 1'b0;
    end

    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_idle_all("reset");
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(20);

    frame(0, 8'hA5, 1'b0, 1'b0, 8'h00);
    idle_cycles(2);
    frame(1, 8'hA5, 1'b0, 1'b0, 8'h00);
    idle_cycles(2);
    frame(2, 8'h3C, 1'b0, 1'b0, 8'h00);
    idle_cycles(2);

    frame(0, 8'hA5, 1'b1, 1'b1, 8'h22);
    frame(0, 8'h22, 1'b0, 1'b0, 8'h00);
    idle_cycles(1);

    reset_mid_frame(8'hC3);
    frame(0, 8'h5A, 1'b0, 1'b0, 8'h00);
    idle_cycles(1);

    for (int it = 0; it < 30; it++) begin
      i     = int'($urandom_range(0, NDUT - 1));
      d     = 8'($urandom);
      links = 0;
      do begin
        chain = ($urandom_range(0, 2) == 0) && (links < 3);
        nd    = 8'($urandom);
        frame(i, d, 1'($urandom), chain, nd);
        d = nd;
        links++;
      end while (chain);
      idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter; the sending end for the team's serial capture/storage blocks.
- Accepts one DATA_WIDTH word through a valid/ready handshake.
- Drives it onto a single line as: start bit, data bits LSB-first, optional parity bit, stop bit.
- Each bit is held for CLKS_PER_BIT clocks; the line idles high.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (>=1).
- CLKS_PER_BIT, 4, clocks each serial bit is held (>=1).
- PARITY_EN, 1, 1 = insert parity bit after data; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity (bit = ^data); 1 = odd parity (bit = ~^data).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  word to send; sampled only on accept.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idle level 1.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous and active-low.
- Reset values, forced immediately on reset_n low: tx_out=1, data_ready=1, busy=0, done=0, state=IDLE, all counters=0.
- Accept: data_valid & data_ready sampled at rising edge E0. data_in is copied into an internal shift register. From E0, state=START and tx_out=0.
- data_ready = (state==IDLE); combinational from state.
- Valid while not ready: ignored. There is no queue. data_in changes during a frame have no effect.
- States and transitions:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT clocks.
  - DATA -> PARITY (PARITY_EN=1) or STOP (PARITY_EN=0) after DATA_WIDTH bits.
  - PARITY -> STOP after CLKS_PER_BIT clocks.
  - STOP -> IDLE after CLKS_PER_BIT clocks.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary. Width is $clog2(CLKS_PER_BIT), minimum 1 bit.
- At each DATA bit boundary the shift register shifts right; tx_out = shift register bit 0.
- Bit index counter counts 0..DATA_WIDTH-1.
- Parity is computed from the word captured at accept, not from the live data_in.
- Frame length: (2 + DATA_WIDTH + PARITY_EN) * CLKS_PER_BIT clocks from E0 to the return to IDLE.
- done: high for exactly the first cycle back in IDLE; busy=0 and data_ready=1 in that same cycle.
- A new accept is allowed in the done cycle. Minimum gap between stop bit and next start bit is 1 clock of idle-high.
- CLKS_PER_BIT=1: every state lasts exactly 1 clock; no extra or stretched bits.
- Reset mid-frame: tx_out returns to 1 asynchronously. The frame is dropped, no done pulse is generated, and transmission does not resume after reset release.
- Reset release: the first accept is possible at the first rising edge with reset_n=1.
- tx_out is registered. There are no glitches at state transitions.

Decomposition:
- Shared package serial_frame_pkg holds:
  - the state encoding: IDLE, START, DATA, PARITY, STOP, 3-bit binary;
  - the constant LINE_IDLE=1'b1;
  - the function frame_clocks(DATA_WIDTH, CLKS_PER_BIT, PARITY_EN).
- One natural sub-module, bit_timer:
  - holds the CLKS_PER_BIT counter, with enable and clear inputs;
  - produces a bit_end strobe;
  - is reused by the matching receiver.
- The FSM, shift register and parity logic stay in serial_frame_tx.

Test Plan:
- Reset and idle, default params:
  - Stimulus: hold reset_n=0 for 3 clocks, then release; data_valid=0 for 20 clocks.
  - Required: tx_out=1, data_ready=1, busy=0, done=0 throughout.
- Single frame, W=8, CPB=4, even parity, data_in=0xA5:
  - Required tx_out sequence, each value held 4 clocks: 0 | 1,0,1,0,0,1,0,1 | 0 | 1.
  - Required: done high exactly at clock 44 after accept; busy high for clocks 0..43.
- Odd parity, data_in=0xA5:
  - Required: parity bit = 1; otherwise identical to the previous scenario.
- No parity, CPB=1, W=8, data_in=0x3C:
  - Required: 10-clock frame, tx_out = 0,0,0,1,1,1,1,0,0,1; done at clock 10.
- Handshake:
  - Assert data_valid with 0x11 mid-frame, and change data_in every cycle mid-frame.
  - Required: neither is accepted or transmitted; the frame in flight is unchanged.
  - Hold valid with 0x22 through the done cycle. Required: accepted there; its start bit begins the next cycle.
- Reset mid-frame:
  - Stimulus: drop reset_n during data bit 3.
  - Required: tx_out=1 and data_ready=1 immediately, with no clock edge needed; no done pulse.
  - Next accept of 0x5A after release: required to produce a complete, correct frame.
